// File: rtl/conv_seq_pkg.sv
// Shared definitions for the conv tile sequencer.
//   - tile geometry localparams
//   - bit positions inside the 34-bit core instruction word
//   - idle instruction constant (both memories deselected, no controls active)
//   - FSM state enum
package conv_seq_pkg;

  localparam int ROW          = 8;
  localparam int COL          = 8;
  localparam int LEN_NIJ      = 36;
  localparam int LEN_ONIJ     = 16;
  localparam int LEN_KIJ      = 9;
  localparam int A_PAD_NI_DIM = 6;
  localparam int O_NI_DIM     = 4;
  localparam int KI_DIM       = 3;
  localparam int W_BASE       = 1024;
  localparam int GAP_CYC      = 10;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  localparam int ACC_BIT      = 33;
  localparam int CEN_PMEM_BIT = 32;
  localparam int WEN_PMEM_BIT = 31;
  localparam int A_PMEM_LSB   = 20;
  localparam int CEN_XMEM_BIT = 19;
  localparam int WEN_XMEM_BIT = 18;
  localparam int A_XMEM_LSB   = 7;
  localparam int OFIFO_RD_BIT = 6;
  localparam int IFIFO_WR_BIT = 5;
  localparam int IFIFO_RD_BIT = 4;
  localparam int L0_RD_BIT    = 3;
  localparam int L0_WR_BIT    = 2;
  localparam int EXECUTE_BIT  = 1;
  localparam int LOAD_BIT     = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0WR,
    S_W_LOAD,
    S_GAP,
    S_A_L0WR,
    S_EXEC,
    S_DRAIN,
    S_OF_RD,
    S_ACC_RD,
    S_ACC_TAIL,
    S_ACC_OUT,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv_seq_addr.sv
// pmem read address for the accumulation pass.
// For output pixel o and kernel position j, selects the partial sum written
// in kij block j at the padded-input position the kernel tap lands on.
// Ports:
//   o      in  4   output pixel index (0..15)
//   j      in  4   kernel position (0..8)
//   a_pmem out 11  pmem address
module conv_seq_addr
  import conv_seq_pkg::*;
(
  input  logic [3:0]        o,
  input  logic [3:0]        j,
  output logic [ADDR_W-1:0] a_pmem
);

  logic [3:0] o_row, o_col, k_row, k_col;

  always_comb begin
    o_row  = o / 4'(O_NI_DIM);
    o_col  = o % 4'(O_NI_DIM);
    k_row  = j / 4'(KI_DIM);
    k_col  = j % 4'(KI_DIM);
    a_pmem = 11'(j) * 11'(LEN_NIJ)
           + 11'(o_row) * 11'(A_PAD_NI_DIM) + 11'(o_col)
           + 11'(k_row) * 11'(A_PAD_NI_DIM) + 11'(k_col);
  end

endmodule

// File: rtl/conv_sequencer.sv
// Instruction sequencer for one conv tile on `core`: nine kij passes
// (weights xmem->L0->PE, activations xmem->L0, execute, drain, OFIFO->pmem)
// followed by the pmem->SFU accumulation pass over all 16 output pixels.
// Every output is registered: a decision taken in cycle n shows up in n+1.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           pulse, begins a tile when idle
//   l0_full         L0 cannot accept a new xmem read
//   ofifo_valid     OFIFO holds a complete row
//   inst[33:0]      core instruction word
//   busy, done      tile in progress / one-cycle completion pulse
//   out_valid       SFU output holds pixel out_idx this cycle
//   out_idx[3:0]    pixel index qualifying out_valid
//   kij[3:0]        kernel position of the current pass
// Optional (macro CONV_SEQ_PERF_EN): stall_cyc, tile_cyc saturating counters.
module conv_sequencer
  import conv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [3:0]        out_idx,
  output logic [3:0]        kij
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [15:0]       stall_cyc,
  output logic [15:0]       tile_cyc
`endif
);

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;        // per-state step / completed-transfer count
  logic [3:0]        kij_cnt_q, kij_cnt_d;
  logic [3:0]        o_q, o_d;
  logic              issue, issue_q;      // xmem read issued this cycle / last cycle
  logic              stall;
  logic              busy_d, done_d, out_valid_d;
  logic [3:0]        out_idx_d, kij_d;
  logic [INST_W-1:0] inst_d;
  logic [ADDR_W-1:0] acc_addr;

  conv_seq_addr u_addr (
    .o      (o_q),
    .j      (cnt_q[3:0]),
    .a_pmem (acc_addr)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    kij_cnt_d   = kij_cnt_q;
    o_d         = o_q;
    issue       = 1'b0;
    stall       = 1'b0;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    inst_d      = INST_IDLE;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_W_L0WR;
          cnt_d     = '0;
          kij_cnt_d = '0;
          o_d       = '0;
        end
      end
      S_W_L0WR: begin
        // Address and count hold while L0 is full; the final pass is a flush
        // cycle that only writes the last read into L0.
        inst_d[A_XMEM_LSB +: ADDR_W] = 11'(W_BASE) + 11'(kij_cnt_q) * 11'(COL) + 11'(cnt_q);
        if (cnt_q < 6'(COL)) begin
          if (l0_full) stall = 1'b1;
          else begin
            issue = 1'b1;
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = S_W_LOAD;
          cnt_d   = '0;
        end
      end
      S_W_LOAD: begin
        inst_d[L0_RD_BIT] = 1'b1;
        inst_d[LOAD_BIT]  = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(COL - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(GAP_CYC - 1)) begin
          state_d = S_A_L0WR;
          cnt_d   = '0;
        end
      end
      S_A_L0WR: begin
        inst_d[A_XMEM_LSB +: ADDR_W] = 11'(cnt_q);
        if (cnt_q < 6'(LEN_NIJ)) begin
          if (l0_full) stall = 1'b1;
          else begin
            issue = 1'b1;
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC, S_DRAIN: begin
        inst_d[L0_RD_BIT]   = 1'b1;
        inst_d[EXECUTE_BIT] = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (state_q == S_EXEC && cnt_q == 6'(LEN_NIJ - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (state_q == S_DRAIN && cnt_q == 6'(ROW + COL - 1)) begin
          state_d = S_OF_RD;
          cnt_d   = '0;
        end
      end
      S_OF_RD: begin
        inst_d[A_PMEM_LSB +: ADDR_W] = 11'(kij_cnt_q) * 11'(LEN_NIJ) + 11'(cnt_q);
        if (ofifo_valid) begin
          inst_d[OFIFO_RD_BIT] = 1'b1;
          inst_d[CEN_PMEM_BIT] = 1'b0;
          inst_d[WEN_PMEM_BIT] = 1'b0;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(LEN_NIJ - 1)) begin
            cnt_d = '0;
            if (kij_cnt_q < 4'(LEN_KIJ - 1)) begin
              kij_cnt_d = kij_cnt_q + 4'd1;
              state_d   = S_W_L0WR;
            end else begin
              state_d = S_ACC_RD;
              o_d     = '0;
            end
          end
        end else begin
          stall = 1'b1;
        end
      end
      S_ACC_RD: begin
        // j=0 loads the SFU, later taps accumulate into it.
        inst_d[CEN_PMEM_BIT]         = 1'b0;
        inst_d[A_PMEM_LSB +: ADDR_W] = acc_addr;
        inst_d[ACC_BIT]              = (cnt_q != '0);
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(LEN_KIJ - 1)) begin
          state_d = S_ACC_TAIL;
          cnt_d   = '0;
        end
      end
      S_ACC_TAIL: begin
        // Absorbs the pmem read latency of the last tap.
        inst_d[ACC_BIT] = 1'b1;
        state_d = S_ACC_OUT;
      end
      S_ACC_OUT: begin
        out_valid_d = 1'b1;
        if (o_q == 4'(LEN_ONIJ - 1)) state_d = S_DONE;
        else begin
          o_d     = o_q + 4'd1;
          state_d = S_ACC_RD;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    inst_d[CEN_XMEM_BIT] = ~issue;
    inst_d[L0_WR_BIT]    = issue_q;   // xmem data arrives one cycle after the read
    inst_d[IFIFO_WR_BIT] = 1'b0;      // ififo path is not used by this dataflow
    inst_d[IFIFO_RD_BIT] = 1'b0;

    busy_d    = (state_q != S_IDLE) && (state_q != S_DONE);
    kij_d     = busy_d ? kij_cnt_q : 4'd0;
    out_idx_d = (state_q == S_ACC_RD || state_q == S_ACC_TAIL || state_q == S_ACC_OUT)
              ? o_q : 4'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the same
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      kij_cnt_q <= '0;
      o_q       <= '0;
      issue_q   <= 1'b0;
      inst      <= INST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      kij       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kij_cnt_q <= kij_cnt_d;
      o_q       <= o_d;
      issue_q   <= issue;
      inst      <= inst_d;
      busy      <= busy_d;
      done      <= done_d;
      out_valid <= out_valid_d;
      out_idx   <= out_idx_d;
      kij       <= kij_d;
    end
  end

`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (state_q == S_IDLE && start)) begin
      stall_cyc <= '0;
      tile_cyc  <= '0;
    end else if (busy_d) begin
      if (stall && stall_cyc != 16'hFFFF) stall_cyc <= stall_cyc + 16'd1;
      if (tile_cyc != 16'hFFFF)           tile_cyc  <= tile_cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer. A tile-level reference model pushes the
// expected xmem reads, pmem writes, accumulation reads and output pixels into
// queues at start; a negedge monitor pops and compares as the DUT emits them.
module tb_conv_sequencer;

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  localparam int B_ACC = 33, B_CEN_P = 32, B_WEN_P = 31, P_LSB = 20;
  localparam int B_CEN_X = 19, B_WEN_X = 18, X_LSB = 7, B_OFRD = 6;
  localparam int B_L0WR = 2, B_EXEC = 1;
  localparam int NO_STALL_BUSY = 1544;

  typedef struct {
    int addr;
    bit acc;
  } pr_t;

  logic        clk = 1'b0;
  logic        reset, start, l0_full, ofifo_valid;
  logic [33:0] inst;
  logic        busy, done, out_valid;
  logic [3:0]  out_idx, kij;
`ifdef CONV_SEQ_PERF_EN
  logic [15:0] stall_cyc, tile_cyc;
`endif

  conv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .l0_full     (l0_full),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .kij         (kij)
`ifdef CONV_SEQ_PERF_EN
    ,
    .stall_cyc   (stall_cyc),
    .tile_cyc    (tile_cyc)
`endif
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  xq[$];
  int  pwq[$];
  pr_t prq[$];
  int  oq[$];
  bit  mon_en = 1'b0;
  int  busy_cnt = 0, done_cnt = 0, ov_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: what one tile must produce, in order, per channel.
  task automatic push_tile();
    for (int k = 0; k < 9; k++) begin
      for (int t = 0; t < 8; t++)  xq.push_back(1024 + k * 8 + t);
      for (int t = 0; t < 36; t++) xq.push_back(t);
      for (int t = 0; t < 36; t++) pwq.push_back(k * 36 + t);
    end
    for (int o = 0; o < 16; o++) begin
      for (int j = 0; j < 9; j++) begin
        int in_row, in_col;
        pr_t e;
        in_row = o / 4 + j / 3;
        in_col = o % 4 + j % 3;
        e.addr = j * 36 + in_row * 6 + in_col;
        e.acc  = (j != 0);
        prq.push_back(e);
      end
      oq.push_back(o);
    end
  endtask

  // Monitor: inputs are driven at posedge+2, so inputs seen at one negedge
  // are the ones behind the inst seen at the next negedge.
  bit prev_xrd, l0f_prev, ofv_prev, exp_tail, exp_out;
  int px_rd;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_xrd = 0; l0f_prev = 0; ofv_prev = 1; exp_tail = 0; exp_out = 0; px_rd = 0;
    end else begin
      bit tail_now, out_now, xrd, pw, pr;
      tail_now = exp_tail; out_now = exp_out;
      exp_tail = 0; exp_out = 0;
      xrd = !inst[B_CEN_X];
      pw  = !inst[B_CEN_P] && !inst[B_WEN_P];
      pr  = !inst[B_CEN_P] &&  inst[B_WEN_P];

      check("l0_wr_trail", inst[B_L0WR], prev_xrd);
      check("ofifo_rd_with_pmem_wr", inst[B_OFRD], pw);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 0);
      end
      if (xrd) begin
        check("xmem_issue_not_full", l0f_prev, 0);
        check("xmem_wen", inst[B_WEN_X], 1);
        if (xq.size() == 0) check("xmem_extra_read", 1, 0);
        else check("xmem_addr", inst[X_LSB +: 11], xq.pop_front());
      end
      if (pw) begin
        check("pmem_wr_ofifo_valid", ofv_prev, 1);
        if (pwq.size() == 0) check("pmem_extra_write", 1, 0);
        else check("pmem_wr_addr", inst[P_LSB +: 11], pwq.pop_front());
      end
      if (pr) begin
        if (prq.size() == 0) check("pmem_extra_read", 1, 0);
        else begin
          pr_t e;
          e = prq.pop_front();
          check("acc_rd_addr", inst[P_LSB +: 11], e.addr);
          check("acc_rd_acc", inst[B_ACC], e.acc);
        end
        px_rd++;
        if (px_rd == 9) begin
          px_rd = 0;
          exp_tail = 1;
        end
      end
      if (tail_now) begin
        check("acc_tail", {inst[B_ACC], inst[B_CEN_P]}, 2'b11);
        exp_out = 1;
      end
      if (out_now) check("out_after_tail", {out_valid, inst[B_ACC]}, 2'b10);
      if (out_valid) begin
        ov_cnt++;
        if (oq.size() == 0) check("out_extra", 1, 0);
        else check("out_idx", out_idx, oq.pop_front());
      end
      prev_xrd = xrd;
      l0f_prev = l0_full;
      ofv_prev = ofifo_valid;
    end
  end

  task automatic clear_sb();
    xq.delete(); pwq.delete(); prq.delete(); oq.delete();
  endtask

  // mode 0: clean (plus a start while busy), 1: 4-cycle l0_full stall at
  // activation read 10, 2: random stalls, 3: reset during EXEC of kij=3.
  task automatic run_tile(input int mode);
    int b0, d0, o0;
    bit hit, stalled;
    hit = 0; stalled = 0;
    push_tile();
    b0 = busy_cnt; d0 = done_cnt; o0 = ov_cnt;
    l0_full = 0; ofifo_valid = 1;
    start = 1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk); #2;
      start = (mode == 0 && cyc == 100);
      if (done) begin
        hit = 1;
        break;
      end
      if (mode == 1 && !stalled && !inst[B_CEN_X] && inst[X_LSB +: 11] == 9) begin
        l0_full = 1;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #2;
          check("stall_addr_hold", inst[X_LSB +: 11], 10);
          check("stall_no_issue", inst[B_CEN_X], 1);
        end
        l0_full = 0;
        stalled = 1;
      end
      if (mode == 2) begin
        l0_full     = ($urandom_range(0, 4) == 0);
        ofifo_valid = ($urandom_range(0, 3) != 0);
      end
      if (mode == 3 && inst[B_EXEC] && kij == 4'd3) begin
        mon_en = 0;
        reset  = 1;
        @(posedge clk); #2;
        reset = 0;
        check("rst_mid_inst", inst, IDLE_INST);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_kij", kij, 0);
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #2;
          check("rst_mid_stays_idle", {busy, inst}, {1'b0, IDLE_INST});
        end
        clear_sb();
        mon_en = 1;
        return;
      end
    end
    l0_full = 0; ofifo_valid = 1;
    if (!hit) check("tile_timeout", 0, 1);
    @(negedge clk); #1;
    if (mode == 0) check("busy_cycles", busy_cnt - b0, NO_STALL_BUSY);
    if (mode == 1) check("busy_cycles_stall", busy_cnt - b0, NO_STALL_BUSY + 4);
    if (mode == 2) check("busy_cycles_min", (busy_cnt - b0) >= NO_STALL_BUSY, 1);
    check("done_pulses", done_cnt - d0, 1);
    check("out_valid_pulses", ov_cnt - o0, 16);
    check("sb_empty", xq.size() + pwq.size() + prq.size() + oq.size(), 0);
`ifdef CONV_SEQ_PERF_EN
    if (mode == 0) begin
      check("tile_cyc", tile_cyc, NO_STALL_BUSY);
      check("stall_cyc", stall_cyc, 0);
    end
    if (mode == 1) begin
      check("tile_cyc_stall", tile_cyc, NO_STALL_BUSY + 4);
      check("stall_cyc_stall", stall_cyc, 4);
    end
`endif
    clear_sb();
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1; start = 0; l0_full = 0; ofifo_valid = 1;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    mon_en = 1;
    repeat (5) @(posedge clk);
    #2;
    check("idle_inst", inst, IDLE_INST);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_out_idx", out_idx, 0);
    check("idle_kij", kij, 0);

    run_tile(0);
    run_tile(1);

    // start coinciding with reset: reset wins, nothing starts.
    reset = 1; start = 1;
    @(posedge clk); #2;
    reset = 0; start = 0;
    repeat (3) begin
      @(posedge clk); #2;
      check("start_with_reset", {busy, inst}, {1'b0, IDLE_INST});
    end

    run_tile(2);
    run_tile(2);
    run_tile(3);
    run_tile(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
